// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock.
// Trial subtraction is a ripple chain of full_addr cells.

module full_addr (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic             dz;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   dw;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] c;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_r_msb;

    // Shift {R,Q} left by one; the stored remainder is always below
    // the divisor, so its top bit never feeds the shifted value.
    assign rs = {r[WIDTH-1:0], q[WIDTH-1]};
    assign dw = {1'b0, d};
    assign unused_r_msb = r[WIDTH];

    // Trial subtract rs - D: invert divisor, carry-in of one.
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        full_addr u_fa (
            .a   (rs[i]),
            .b   (~dw[i]),
            .cin (c[i]),
            .sum (t[i]),
            .cout(c[i+1])
        );
    end

    // Carry-out high means the difference is non-negative.
    assign r_next = c[WIDTH+1] ? t : rs;
    assign q_next = {q[WIDTH-2:0], c[WIDTH+1]};

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        q     <= dividend;
                        d     <= divisor;
                        r     <= '0;
                        cnt   <= '0;
                        dz    <= (divisor == '0);
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= dz;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
